riscv_lsu: RTL and testbench

Load/store unit that consumes the memory controls produced by the instruction decoder: request, write enable and size code (B/H/W/BU/HU). It turns them into a word-aligned data-memory bus transaction with byte enables and lane-replicated write data, and stalls the core until the memory responds. Load data is sign- or zero-extended before it is returned to the writeback mux. It sits between the execute stage and the data memory.

---
 rtl/riscv_lsu.sv | 108 ++++++++++
 tb/tb_riscv_lsu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit turning decoder memory controls into a stalled, word-aligned data-memory access
// Ports: clk_i/arstn_i clock and async active-low reset; core_req_i/core_we_i/core_size_i/core_addr_i/core_wd_i
// access request from execute; core_rd_o extended load data (valid in DONE); core_stall_req_o pipeline hold;
// bus_err_o timeout pulse; misaligned_o misalignment pulse; mem_* word-aligned bus with byte enables.
// Optional: define LSU_MISALIGN_EN to trap misaligned H/HU/W accesses without touching memory.
module riscv_lsu #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_req_o,
  output logic        bus_err_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wd_q, cnt, rd_fmt, wd_fmt;
  logic [1:0]  a;
  logic [3:0]  be;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic        is_b, is_h, mis_in;
  assign a = addr_q[1:0];
  // undefined size codes fall through to word handling
  always_comb begin
    is_b   = size_q == 3'd0 || size_q == 3'd4;
    is_h   = size_q == 3'd1 || size_q == 3'd5;
    be     = is_b ? 4'b0001 << a : is_h ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    rb     = mem_rd_i[8*a +: 8];
    rh     = a[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    rd_fmt = size_q == 3'd0 ? {{24{rb[7]}}, rb} :
             size_q == 3'd4 ? {24'b0, rb} :
             size_q == 3'd1 ? {{16{rh[15]}}, rh} :
             size_q == 3'd5 ? {16'b0, rh} : mem_rd_i;
    wd_fmt = is_b ? {4{wd_q[7:0]}} : is_h ? {2{wd_q[15:0]}} : wd_q;
  end
`ifdef LSU_MISALIGN_EN
  logic in_b, in_h;
  assign in_b   = core_size_i == 3'd0 || core_size_i == 3'd4;
  assign in_h   = core_size_i == 3'd1 || core_size_i == 3'd5;
  assign mis_in = (in_h && core_addr_i[0]) || (!in_b && !in_h && |core_addr_i[1:0]);
`else
  assign mis_in = 1'b0;
`endif
  assign mem_req_o        = state == BUSY;
  assign mem_we_o         = state == BUSY && we_q;
  assign mem_be_o         = state == BUSY ? be : 4'b0000;
  assign mem_addr_o       = {addr_q[31:2], 2'b00};
  assign mem_wd_o         = wd_fmt;
  assign core_stall_req_o = state == IDLE ? core_req_i : state == BUSY;
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 3'd0;
      addr_q       <= 32'd0;
      wd_q         <= 32'd0;
      cnt          <= 32'd0;
      core_rd_o    <= 32'd0;
      bus_err_o    <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (core_req_i) begin
          we_q   <= core_we_i;
          size_q <= core_size_i;
          addr_q <= core_addr_i;
          wd_q   <= core_wd_i;
          if (mis_in) begin
            state        <= DONE;
            misaligned_o <= 1'b1;
            core_rd_o    <= 32'd0;
          end else state <= BUSY;
        end
        BUSY: if (mem_ready_i) begin
          if (!we_q) core_rd_o <= rd_fmt;
          state <= DONE;
        end else if (MEM_TIMEOUT != 0 && cnt == 32'(MEM_TIMEOUT - 1)) begin
          state     <= DONE;
          core_rd_o <= 32'd0;
          bus_err_o <= 1'b1;
        end else cnt <= cnt + 32'd1;
        DONE: begin
          state        <= IDLE;
          cnt          <= 32'd0;
          bus_err_o    <= 1'b0;
          misaligned_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed self-checking bench for riscv_lsu
module tb_riscv_lsu;
  logic        clk_i = 1'b0, arstn_i = 1'b0;
  logic        core_req_i = 1'b0, core_we_i = 1'b0, mem_ready_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = 32'd0, core_wd_i = 32'd0, mem_rd_i = 32'd0;
  logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
  logic        core_stall_req_o, bus_err_o, misaligned_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  int total = 0, bad = 0;

  riscv_lsu #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_req_o(core_stall_req_o), .bus_err_o(bus_err_o),
    .misaligned_o(misaligned_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                     input logic [31:0] wd, input logic rdy, input logic [31:0] rd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = rdy;
    mem_rd_i    = rd;
    #1;
  endtask

  task automatic finish_access;
    core_req_i  = 1'b0;
    mem_ready_i = 1'b0;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(core_stall_req_o), 32'd0);
    chk("rst_rd", core_rd_o, 32'd0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    chk("rst_mis", 32'(misaligned_o), 32'd0);
    #4 arstn_i = 1'b1;
    tick;

    // SW 0x104, zero-wait
    req(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 1'b1, 32'h12345678);
    chk("sw_idle_stall", 32'(core_stall_req_o), 32'd1);
    chk("sw_idle_req", 32'(mem_req_o), 32'd0);
    tick;
    chk("sw_req", 32'(mem_req_o), 32'd1);
    chk("sw_we", 32'(mem_we_o), 32'd1);
    chk("sw_be", 32'(mem_be_o), 32'hF);
    chk("sw_addr", mem_addr_o, 32'h104);
    chk("sw_wd", mem_wd_o, 32'hDEADBEEF);
    chk("sw_busy_stall", 32'(core_stall_req_o), 32'd1);
    tick;
    chk("sw_done_stall", 32'(core_stall_req_o), 32'd0);
    chk("sw_done_req", 32'(mem_req_o), 32'd0);
    chk("sw_done_we", 32'(mem_we_o), 32'd0);
    chk("sw_rd_kept", core_rd_o, 32'd0);
    finish_access;
    chk("sw_idle_after", 32'(core_stall_req_o), 32'd0);

    // SB 0x203
    req(1'b1, 3'd0, 32'h203, 32'h000000A5, 1'b1, 32'h12345678);
    tick;
    chk("sb_be", 32'(mem_be_o), 32'h8);
    chk("sb_wd", mem_wd_o, 32'hA5A5A5A5);
    chk("sb_addr", mem_addr_o, 32'h200);
    tick;
    chk("sb_rd_kept", core_rd_o, 32'd0);
    finish_access;

    // SH 0x102 and undefined size 3 as word store
    req(1'b1, 3'd1, 32'h102, 32'h0000BEEF, 1'b1, 32'h0);
    tick;
    chk("sh_be", 32'(mem_be_o), 32'hC);
    chk("sh_wd", mem_wd_o, 32'hBEEFBEEF);
    tick;
    finish_access;
    req(1'b1, 3'd3, 32'h800, 32'h11223344, 1'b1, 32'h0);
    tick;
    chk("s3_be", 32'(mem_be_o), 32'hF);
    chk("s3_wd", mem_wd_o, 32'h11223344);
    tick;
    finish_access;

    // LB / LBU / LH / LHU
    req(1'b0, 3'd0, 32'h302, 32'h0, 1'b1, 32'h11803344);
    tick;
    chk("lb_be", 32'(mem_be_o), 32'h4);
    chk("lb_we", 32'(mem_we_o), 32'd0);
    tick;
    chk("lb_rd", core_rd_o, 32'hFFFFFF80);
    finish_access;
    req(1'b0, 3'd4, 32'h302, 32'h0, 1'b1, 32'h11803344);
    tick;
    tick;
    chk("lbu_rd", core_rd_o, 32'h00000080);
    finish_access;
    req(1'b0, 3'd1, 32'h302, 32'h0, 1'b1, 32'h80011234);
    tick;
    chk("lh_be", 32'(mem_be_o), 32'hC);
    tick;
    chk("lh_rd", core_rd_o, 32'hFFFF8001);
    finish_access;
    req(1'b0, 3'd5, 32'h300, 32'h0, 1'b1, 32'h80019234);
    tick;
    chk("lhu_be", 32'(mem_be_o), 32'h3);
    tick;
    chk("lhu_rd", core_rd_o, 32'h00009234);
    finish_access;

    // LW with 3 wait cycles
    req(1'b0, 3'd2, 32'h400, 32'h0, 1'b0, 32'hCAFEF00D);
    chk("lw3_stall0", 32'(core_stall_req_o), 32'd1);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("lw3_wait_req", 32'(mem_req_o), 32'd1);
      chk("lw3_wait_stall", 32'(core_stall_req_o), 32'd1);
      tick;
    end
    mem_ready_i = 1'b1;
    chk("lw3_last_req", 32'(mem_req_o), 32'd1);
    tick;
    chk("lw3_done_req", 32'(mem_req_o), 32'd0);
    chk("lw3_done_stall", 32'(core_stall_req_o), 32'd0);
    chk("lw3_rd", core_rd_o, 32'hCAFEF00D);
    chk("lw3_err", 32'(bus_err_o), 32'd0);
    finish_access;

    // timeout after 4 BUSY cycles
    req(1'b0, 3'd2, 32'h500, 32'h0, 1'b0, 32'h5A5A5A5A);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_req", 32'(mem_req_o), 32'd1);
      chk("to_wait_err", 32'(bus_err_o), 32'd0);
      tick;
    end
    chk("to_err", 32'(bus_err_o), 32'd1);
    chk("to_rd", core_rd_o, 32'd0);
    chk("to_stall", 32'(core_stall_req_o), 32'd0);
    finish_access;
    chk("to_err_pulse", 32'(bus_err_o), 32'd0);

    // reset mid-BUSY
    req(1'b0, 3'd2, 32'h600, 32'h0, 1'b0, 32'h0);
    tick;
    chk("rb_req", 32'(mem_req_o), 32'd1);
    #2;
    arstn_i    = 1'b0;
    core_req_i = 1'b0;
    #1;
    chk("rb_req_fall", 32'(mem_req_o), 32'd0);
    chk("rb_stall_fall", 32'(core_stall_req_o), 32'd0);
    #1 arstn_i = 1'b1;
    tick;
    req(1'b0, 3'd2, 32'h700, 32'h0, 1'b1, 32'h0000ABCD);
    tick;
    chk("rb_next_addr", mem_addr_o, 32'h700);
    tick;
    chk("rb_next_rd", core_rd_o, 32'h0000ABCD);
    finish_access;

    // LW to 0x101
    req(1'b0, 3'd2, 32'h101, 32'h0, 1'b1, 32'h55AA55AA);
    chk("mis_stall0", 32'(core_stall_req_o), 32'd1);
    tick;
`ifdef LSU_MISALIGN_EN
    chk("mis_req", 32'(mem_req_o), 32'd0);
    chk("mis_flag", 32'(misaligned_o), 32'd1);
    chk("mis_rd", core_rd_o, 32'd0);
    chk("mis_stall", 32'(core_stall_req_o), 32'd0);
    finish_access;
    chk("mis_pulse", 32'(misaligned_o), 32'd0);
`else
    chk("mis_req", 32'(mem_req_o), 32'd1);
    chk("mis_addr", mem_addr_o, 32'h100);
    chk("mis_be", 32'(mem_be_o), 32'hF);
    chk("mis_flag", 32'(misaligned_o), 32'd0);
    tick;
    chk("mis_rd", core_rd_o, 32'h55AA55AA);
    chk("mis_flag_done", 32'(misaligned_o), 32'd0);
    finish_access;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
